serial_bus_master: RTL and testbench

SERIAL_BUS_MASTER -- requirements
Module: serial_bus_master

---
 rtl/serial_bus_master.sv | 123 ++++++++++++
 tb/tb_serial_bus_master.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_master.sv
// rtl/serial_bus_master.sv - byte-command driven Z80-style memory bus master
// Parses 'W'/'R' commands from a byte stream and runs single-cycle write / two-cycle read bus cycles.
module serial_bus_master #(
    parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        mreq,
    output logic        rd,
    output logic        wr,
    output logic [15:0] addr,
    output logic [7:0]  data_out,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic        err
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN, S_WDATA,
        S_WCYC, S_RCYC1, S_RCYC2, S_TXB, S_TXACK
    } state_t;

    state_t      state, state_nx;
    logic        is_write;
    logic [8:0]  count;
    logic [23:0] tmo_cnt;
    logic        timed, timeout, handshake, rx_is_cmd, rx_dropped;

    assign timed      = (state inside {S_ADDR_H, S_ADDR_L, S_LEN, S_WDATA});
    // A byte landing on the expiry cycle wins over the timeout.
    assign timeout    = timed && !rx_valid && (tmo_cnt == TIMEOUT - 24'd1);
    assign handshake  = tx_valid && tx_ready;
    assign rx_is_cmd  = (rx_data == 8'h57) || (rx_data == 8'h52);
    assign rx_dropped = rx_valid && (state inside {S_WCYC, S_RCYC1, S_RCYC2, S_TXB, S_TXACK});

    // Strobes decode straight from state so an async reset removes them at once.
    assign mreq     = (state inside {S_WCYC, S_RCYC1, S_RCYC2});
    assign wr       = (state == S_WCYC);
    assign rd       = (state inside {S_RCYC1, S_RCYC2});
    assign tx_valid = (state inside {S_TXB, S_TXACK});
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (rx_valid) state_nx = rx_is_cmd ? S_ADDR_H : S_TXACK;
            S_ADDR_H: if (timeout) state_nx = S_IDLE; else if (rx_valid) state_nx = S_ADDR_L;
            S_ADDR_L: if (timeout) state_nx = S_IDLE; else if (rx_valid) state_nx = S_LEN;
            S_LEN:    if (timeout) state_nx = S_IDLE;
                      else if (rx_valid) state_nx = is_write ? S_WDATA : S_RCYC1;
            S_WDATA:  if (timeout) state_nx = S_IDLE; else if (rx_valid) state_nx = S_WCYC;
            S_WCYC:   state_nx = (count == 9'd1) ? S_TXACK : S_WDATA;
            S_RCYC1:  state_nx = S_RCYC2;
            S_RCYC2:  state_nx = S_TXB;
            S_TXB:    if (handshake) state_nx = (count != 9'd0) ? S_RCYC1 : S_IDLE;
            S_TXACK:  if (handshake) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            is_write <= 1'b0;
            addr     <= 16'h0000;
            count    <= 9'd0;
            data_out <= 8'h00;
            tx_data  <= 8'h00;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_valid && rx_is_cmd) begin
                        is_write <= (rx_data == 8'h57);
                        err      <= 1'b0;
                    end else if (rx_valid) begin
                        tx_data <= 8'h3F;
                    end
                end
                S_ADDR_H: if (rx_valid) addr[15:8] <= rx_data;
                S_ADDR_L: if (rx_valid) addr[7:0]  <= rx_data;
                // LEN of zero encodes 256 via the ninth bit.
                S_LEN:    if (rx_valid) count <= {(rx_data == 8'h00), rx_data};
                S_WDATA:  if (rx_valid) data_out <= rx_data;
                S_WCYC: begin
                    addr  <= addr + 16'd1;
                    count <= count - 9'd1;
                    if (count == 9'd1) tx_data <= 8'h4B;
                end
                S_RCYC2: begin
                    tx_data <= data_in;
                    addr    <= addr + 16'd1;
                    count   <= count - 9'd1;
                end
                default: ;
            endcase
            if (timeout || rx_dropped) err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_cnt <= 24'd0;
        end else if (timed && !rx_valid) begin
            tmo_cnt <= tmo_cnt + 24'd1;
        end else begin
            tmo_cnt <= 24'd0;
        end
    end

endmodule

// File: tb/tb_serial_bus_master.sv
// tb/tb_serial_bus_master.sv - self-checking bench for serial_bus_master
module tb_serial_bus_master;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        mreq, rd, wr;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic [7:0]  data_in;
    logic        busy, err;

    serial_bus_master #(.TIMEOUT(24'd100)) dut (
        .clk(clk), .n_rst(n_rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .mreq(mreq), .rd(rd), .wr(wr), .addr(addr), .data_out(data_out),
        .data_in(data_in), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return ~a[7:0] ^ a[15:8];
    endfunction

    // Bus-side memory, written only by the monitor when the DUT strobes wr.
    bit [7:0] ram   [0:65535];
    bit       wmark [0:65535];
    assign data_in = wmark[addr] ? ram[addr] : dflt(addr);

    int rdy_mode = 1;  // 0: held low, 1: held high, 2: random
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic [15:0] wq_a[$];
    logic [7:0]  wq_d[$];
    logic [15:0] rq_a[$];
    logic [7:0]  tq[$];
    int          stab_bad = 0;
    int          bad_strobe = 0;
    logic        pend = 1'b0;
    logic [7:0]  pend_data = 8'h00;

    always @(negedge clk) begin
        if (n_rst) begin
            if (mreq && wr) begin
                wq_a.push_back(addr);
                wq_d.push_back(data_out);
                ram[addr]   = data_out;
                wmark[addr] = 1'b1;
            end
            if (mreq && rd) rq_a.push_back(addr);
            if (tx_valid && tx_ready) tq.push_back(tx_data);
            if (pend && (!tx_valid || tx_data != pend_data)) stab_bad++;
            pend      = tx_valid && !tx_ready;
            pend_data = tx_data;
            if (((rd || wr) && !mreq) || (rd && wr)) bad_strobe++;
        end else begin
            pend = 1'b0;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: shadow memory and expected sticky error.
    bit [7:0] mdl_mem  [0:65535];
    bit       mdl_mark [0:65535];
    logic     exp_err = 1'b0;

    function automatic logic [7:0] mdl_rd(input logic [15:0] a);
        return mdl_mark[a] ? mdl_mem[a] : dflt(a);
    endfunction

    task automatic send_raw(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_raw(b);
        repeat ($urandom_range(3, 6)) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_bound", 32'(busy), 32'd0);
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [15:0] a, input logic [7:0] len,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input int exp_cyc, input int exp_ntx);
        logic [7:0]  dat[256];
        logic [15:0] ea;
        int n, w0, r0, t0;
        n  = (len == 8'h00) ? 256 : int'(len);
        foreach (dat[i]) dat[i] = 8'($urandom);
        dat[0] = d0;
        dat[1] = d1;
        w0 = wq_a.size(); r0 = rq_a.size(); t0 = tq.size();
        send_byte(op);
        if (op == 8'h57 || op == 8'h52) begin
            send_byte(a[15:8]);
            send_byte(a[7:0]);
            send_byte(len);
            if (op == 8'h57) for (int i = 0; i < n; i++) send_byte(dat[i]);
        end
        wait_idle();
        if (op == 8'h57) begin
            exp_err = 1'b0;
            chk("wr_count", wq_a.size() - w0, n);
            chk("rd_count_on_write", rq_a.size() - r0, 0);
            for (int i = 0; i < n; i++) begin
                ea = a + 16'(i);
                chk("wr_addr", wq_a[w0 + i], ea);
                chk("wr_data", wq_d[w0 + i], dat[i]);
                mdl_mem[ea]  = dat[i];
                mdl_mark[ea] = 1'b1;
            end
            chk("tx_count", tq.size() - t0, 1);
            chk("tx_ack", tq[t0], 8'h4B);
        end else if (op == 8'h52) begin
            exp_err = 1'b0;
            chk("rd_count", rq_a.size() - r0, 2 * n);
            chk("wr_count_on_read", wq_a.size() - w0, 0);
            chk("tx_count", tq.size() - t0, n);
            for (int i = 0; i < n; i++) begin
                ea = a + 16'(i);
                chk("rd_addr_a", rq_a[r0 + 2 * i], ea);
                chk("rd_addr_b", rq_a[r0 + 2 * i + 1], ea);
                chk("rd_tx_data", tq[t0 + i], mdl_rd(ea));
            end
        end else begin
            chk("bad_bus", (wq_a.size() - w0) + (rq_a.size() - r0), 0);
            chk("bad_tx_count", tq.size() - t0, 1);
            chk("bad_tx", tq[t0], 8'h3F);
        end
        if (exp_cyc >= 0) chk("tbl_cycles", (wq_a.size() - w0) + (rq_a.size() - r0), exp_cyc);
        if (exp_ntx >= 0) chk("tbl_ntx", tq.size() - t0, exp_ntx);
        chk("err", 32'(err), 32'(exp_err));
        chk("tx_stable", stab_bad, 0);
        chk("strobe_shape", bad_strobe, 0);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [15:0] a;
        logic [7:0]  len;
        logic [7:0]  d0;
        logic [7:0]  d1;
        int          cyc;
        int          ntx;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int t0, r0, w0;
        logic [7:0]  op;
        logic [15:0] a;
        logic [7:0]  len;

        tbl[0] = '{8'h57, 16'h8010, 8'h02, 8'hAA, 8'hBB, 2,   1};
        tbl[1] = '{8'h52, 16'h8010, 8'h02, 8'h00, 8'h00, 4,   2};
        tbl[2] = '{8'h57, 16'hFFFF, 8'h02, 8'h11, 8'h22, 2,   1};
        tbl[3] = '{8'h52, 16'h0000, 8'h00, 8'h00, 8'h00, 512, 256};
        tbl[4] = '{8'h41, 16'h0000, 8'h00, 8'h00, 8'h00, 0,   1};
        tbl[5] = '{8'h57, 16'h1234, 8'h01, 8'h5C, 8'h00, 1,   1};
        tbl[6] = '{8'h52, 16'hFFFE, 8'h03, 8'h00, 8'h00, 6,   3};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mreq", 32'(mreq), 0);
        chk("rst_rd_wr", {rd, wr}, 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_busy_err", {busy, err}, 0);
        n_rst = 1'b1;

        rdy_mode = 2;
        for (int i = 0; i < 7; i++)
            run_cmd(tbl[i].op, tbl[i].a, tbl[i].len, tbl[i].d0, tbl[i].d1, tbl[i].cyc, tbl[i].ntx);

        // Read held in TXB with tx_ready low, plus a stray byte while busy.
        rdy_mode = 0;
        t0 = tq.size(); r0 = rq_a.size();
        send_byte(8'h52); send_byte(8'h80); send_byte(8'h10); send_byte(8'h02);
        repeat (10) @(negedge clk);
        chk("hold_valid", 32'(tx_valid), 1);
        chk("hold_data", tx_data, 8'hAA);
        chk("hold_reads", rq_a.size() - r0, 2);
        send_raw(8'h99);
        @(negedge clk);
        chk("stray_err", 32'(err), 1);
        exp_err = 1'b1;
        rdy_mode = 1;
        wait_idle();
        chk("hold_ntx", tq.size() - t0, 2);
        chk("hold_tx0", tq[t0], 8'hAA);
        chk("hold_tx1", tq[t0 + 1], 8'hBB);
        chk("hold_reads_all", rq_a.size() - r0, 4);
        chk("hold_stable", stab_bad, 0);
        chk("hold_err_sticky", 32'(err), 1);

        // Timeout: stall after 57 80.
        w0 = wq_a.size(); r0 = rq_a.size(); t0 = tq.size();
        send_raw(8'h57);
        send_raw(8'h80);
        repeat (98) @(posedge clk);
        #1;
        chk("tmo_err_early", 32'(err), 0);
        @(posedge clk); #1;
        chk("tmo_cycle99", {busy, err}, 2'b10);
        @(posedge clk); #1;
        chk("tmo_cycle100", {busy, err}, 2'b01);
        repeat (3) @(posedge clk);
        chk("tmo_no_bus", (wq_a.size() - w0) + (rq_a.size() - r0) + (tq.size() - t0), 0);
        exp_err = 1'b1;

        // Byte arriving on the expiry cycle is accepted.
        send_raw(8'h57);
        send_raw(8'h80);
        repeat (99) @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = 8'h10;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        chk("tmo_edge_accept", {busy, err}, 2'b10);
        w0 = wq_a.size(); t0 = tq.size();
        send_byte(8'h01);
        send_byte(8'h55);
        wait_idle();
        exp_err = 1'b0;
        mdl_mem[16'h8010] = 8'h55;
        chk("tmo_edge_wr", {wq_a[w0], wq_d[w0]}, {16'h8010, 8'h55});
        chk("tmo_edge_ack", tq[t0], 8'h4B);
        chk("tmo_edge_err", 32'(err), 0);

        // Reset during RCYC1.
        r0 = rq_a.size(); t0 = tq.size();
        send_raw(8'h52); send_raw(8'h12); send_raw(8'h34); send_raw(8'h01);
        chk("pre_rst_strobe", {mreq, rd, wr}, 3'b110);
        n_rst = 1'b0;
        #1;
        chk("rst_mid_strobe", {mreq, rd, wr}, 3'b000);
        chk("rst_mid_state", {busy, err, tx_valid}, 3'b000);
        chk("rst_mid_regs", {addr, data_out, tx_data}, 32'h0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        chk("rst_mid_noread", (rq_a.size() - r0) + (tq.size() - t0), 0);
        exp_err = 1'b0;
        run_cmd(8'h57, 16'h8000, 8'h01, 8'h55, 8'h00, 1, 1);

        // Randomised commands against the model.
        rdy_mode = 2;
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 9))
                0:       op = 8'h30 + 8'($urandom_range(0, 15));
                1, 2, 3, 4: op = 8'h57;
                default: op = 8'h52;
            endcase
            a   = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
            len = ($urandom_range(0, 19) == 0) ? 8'h00 : 8'($urandom_range(1, 6));
            run_cmd(op, a, len, 8'($urandom), 8'($urandom), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
